mux_n_pipe: RTL
===============

# mux_n_pipe

Parametrised N-way, W-bit registered selector with valid/ready flow control, the next generation of the datapath 2:1 word mux. It selects one of NUM_IN operand words per transaction, registers the result, and absorbs downstream back-pressure with a 2-entry skid buffer. Sustained throughput is one word per cycle. It sits between the register-file/forwarding sources and the ALU operand port in the pipelined mips32 datapath.

## Interface
- WIDTH, 32, data word width in bits (≥1)
- NUM_IN, 4, number of selectable inputs (≥2; need not be a power of two)
- SEL_W, $clog2(NUM_IN), select width (derived, not overridden)

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- flush  in  1  synchronous clear of all buffered words
- in_valid  in  1  upstream word available
- in_ready  out  1  block can accept this cycle
- in_data  in  NUM_IN*WIDTH  packed inputs; input k = in_data[k*WIDTH +: WIDTH]
- in_sel  in  SEL_W  index of the selected input
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  selected word
- out_err  out  1  word came from an out-of-range in_sel

## Operation
- Accept on in_valid && in_ready; consume on out_valid && out_ready.
- Selection: in_sel < NUM_IN → word = input[in_sel], err = 0; in_sel ≥ NUM_IN → word = 0, err = 1.
- Storage: main register (drives outputs) plus skid register; each holds {word, err}.
- States: EMPTY (none held), ONE (main held), TWO (main + skid held).
  - EMPTY: accept → ONE (load main).
  - ONE: accept & consume → ONE (reload main); accept only → TWO (load skid); consume only → EMPTY.
  - TWO: consume → ONE (skid moves to main); no accept possible.
- in_ready = (state != TWO). It is registered-state derived and has no combinational path from out_ready.
- out_valid = (state != EMPTY).
- flush: next state EMPTY, and accepts in that cycle are dropped. Flush overrides accept and consume.
- Order is strictly preserved. No word is duplicated or lost except through flush.
- Data registers need not clear on consume. out_data while out_valid = 0 is don't-care after reset, but a verifier must not check it.

## Timing
- Reset (rst_n low, async): state EMPTY, out_valid 0, out_data 0, out_err 0, in_ready 1.
- Reset mid-operation discards all held words immediately, not waiting for a clock edge.
- Latency: word accepted at edge n is visible on out_data after edge n, with out_valid high in cycle n+1.
- Back-pressure: with out_ready low, two words are accepted, then in_ready drops in the cycle after the second accept.
- in_ready returns high the cycle after the first consume from TWO.
- Simultaneous accept and consume in ONE keeps full throughput with no bubble.
- Flush and rst_n deassertion in the same cycle: reset state holds, and the first accept can occur on the next edge.

## Structure
- Shared package mips32_pkg: WORD_W = 32, and a function clog2_min1 (returns ≥1) used for SEL_W.
- Sub-module mux_n_comb: purely combinational WIDTH/NUM_IN selector producing {word, err}. It replaces chained 2:1 word muxes.
- mux_n_pipe contains only the state register, the main/skid registers, and the handshake logic.

## Test plan
- Streaming, NUM_IN=4, WIDTH=32, out_ready=1: inputs {0x11111111, 0x22222222, 0x33333333, 0x44444444}, sel 2,0,3 on consecutive cycles → out_data 0x33333333, 0x11111111, 0x44444444 on consecutive cycles; in_ready never drops.
- Back-pressure: out_ready=0, offer sel 1 then 2 → in_ready low after the second accept. Release out_ready → outputs 0x22222222, then 0x33333333, in order with none lost.
- Out-of-range, NUM_IN=3: sel=3 → out_data 0x00000000, out_err=1. The next word with sel=1 → out_err=0.
- Flush in TWO with an offered third word → next cycle out_valid=0, in_ready=1, and the third word does not appear.
- Async reset asserted mid-stream in state ONE → out_valid, out_data and out_err go to 0 before the next edge, and in_ready=1.
- Random valid/ready throttling, 10k words, against a scoreboard of selected words → exact order match with zero loss.

Source files
------------

// File: rtl/mips32_pkg.sv
// rtl/mips32_pkg.sv - shared datapath constants, skid-buffer states and width helper
package mips32_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

    // Select width for an N-way mux; a 1-input or 2-input mux still needs one bit.
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_n_comb.sv
// rtl/mux_n_comb.sv - combinational N-way word selector with out-of-range flag
module mux_n_comb #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    output logic [WIDTH-1:0]        word,
    output logic                    err
);

    // A select that matches no input yields a zero word with err raised.
    always_comb begin
        word = '0;
        err  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                word = in_data[k*WIDTH +: WIDTH];
                err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_n_pipe.sv
// rtl/mux_n_pipe.sv - registered N-way selector with valid/ready and 2-entry skid buffer
module mux_n_pipe
    import mips32_pkg::*;
#(
    parameter int  WIDTH  = WORD_W,
    parameter int  NUM_IN = 4,
    localparam int SEL_W  = clog2_min1(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err
);

    skid_state_t      state_q, state_d;
    logic [WIDTH-1:0] sel_word, main_word_q, skid_word_q;
    logic             sel_err, main_err_q, skid_err_q;
    logic             accept, consume;
    logic             load_main, load_skid, main_from_skid;

    mux_n_comb #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_sel (
        .in_data (in_data),
        .in_sel  (in_sel),
        .word    (sel_word),
        .err     (sel_err)
    );

    // Both handshake outputs come from the state register only, so in_ready
    // never depends combinationally on out_ready.
    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_word_q;
    assign out_err   = main_err_q;

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d   = ST_ONE;
                        load_main = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        state_d   = ST_TWO;
                        load_skid = 1'b1;
                    end else if (consume) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (consume) begin
                        state_d        = ST_ONE;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            main_word_q <= '0;
            main_err_q  <= 1'b0;
            skid_word_q <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_main) begin
                main_word_q <= sel_word;
                main_err_q  <= sel_err;
            end else if (main_from_skid) begin
                main_word_q <= skid_word_q;
                main_err_q  <= skid_err_q;
            end
            if (load_skid) begin
                skid_word_q <= sel_word;
                skid_err_q  <= sel_err;
            end
        end
    end

endmodule
